// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath width, load-type codes and writeback state encoding.
package cpu_defs;

  localparam int XLEN = 32;

  localparam logic [2:0] LOAD_LW  = 3'd0;
  localparam logic [2:0] LOAD_LB  = 3'd1;
  localparam logic [2:0] LOAD_LBU = 3'd2;
  localparam logic [2:0] LOAD_LH  = 3'd3;
  localparam logic [2:0] LOAD_LHU = 3'd4;

  typedef enum logic [1:0] {
    WB_EMPTY     = 2'd0,
    WB_HOLD      = 2'd1,
    WB_WAIT_LOAD = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the byte/half addressed by the load offset and extends it.
module load_align
  import cpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  op,
  output logic [31:0] value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select then extend; off[0] is ignored for halves since misalignment traps upstream.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    value  = rdata;
    case (off)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (off[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (op)
      LOAD_LB:  value = {{24{byte_s[7]}}, byte_s};
      LOAD_LBU: value = {24'h000000, byte_s};
      LOAD_LH:  value = {{16{half_s[15]}}, half_s};
      LOAD_LHU: value = {16'h0000, half_s};
      default:  value = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: one-entry holding register with valid/allowin handshake,
// variable-latency load completion, register-file write, forwarding and retire counting.
module wb_stage
  import cpu_defs::*;
#(
  parameter int XLEN  = cpu_defs::XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ms_valid,
  output logic             ws_allowin,
  input  logic [XLEN-1:0]  ms_pc,
  input  logic [4:0]       ms_dest,
  input  logic             ms_reg_write,
  input  logic [XLEN-1:0]  ms_result,
  input  logic             ms_is_load,
  input  logic [2:0]       ms_load_op,
  input  logic             data_rvalid,
  input  logic [XLEN-1:0]  data_rdata,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic             fwd_pending,
  output logic [4:0]       fwd_dest,
  output logic [XLEN-1:0]  fwd_data,
  output logic [XLEN-1:0]  debug_wb_pc,
  output logic [CNT_W-1:0] retire_cnt
);

  wb_state_e        state_r;
  wb_state_e        state_nxt_s;
  logic [XLEN-1:0]  pc_r;
  logic [4:0]       dest_r;
  logic             reg_write_r;
  logic [XLEN-1:0]  result_r;
  logic [2:0]       load_op_r;
  logic [CNT_W-1:0] cnt_r;

  logic             ws_valid_s;
  logic             held_load_s;
  logic             ready_go_s;
  logic             accept_s;
  logic             writes_rf_s;
  logic [XLEN-1:0]  aligned_s;
  logic [XLEN-1:0]  wdata_s;

  load_align u_load_align (
    .rdata (data_rdata),
    .off   (result_r[1:0]),
    .op    (load_op_r),
    .value (aligned_s)
  );

  // Handshake decode and next state; a commit with a same-cycle accept jumps straight to the new instruction's state.
  always_comb begin
    ws_valid_s  = 1'b0;
    held_load_s = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      WB_EMPTY: begin
        ws_valid_s  = 1'b0;
        held_load_s = 1'b0;
      end
      WB_HOLD: begin
        ws_valid_s  = 1'b1;
        held_load_s = 1'b0;
      end
      WB_WAIT_LOAD: begin
        ws_valid_s  = 1'b1;
        held_load_s = 1'b1;
      end
      default: begin
        ws_valid_s  = 1'b0;
        held_load_s = 1'b0;
      end
    endcase
    ready_go_s = ws_valid_s && (!held_load_s || data_rvalid);
    ws_allowin = !ws_valid_s || ready_go_s;
    accept_s   = ms_valid && ws_allowin;
    if (accept_s) begin
      if (ms_is_load) begin
        state_nxt_s = WB_WAIT_LOAD;
      end else begin
        state_nxt_s = WB_HOLD;
      end
    end else if (ready_go_s || !ws_valid_s) begin
      state_nxt_s = WB_EMPTY;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= WB_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Stage payload captured on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r        <= {XLEN{1'b0}};
      dest_r      <= 5'd0;
      reg_write_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      load_op_r   <= 3'd0;
    end else if (accept_s) begin
      pc_r        <= ms_pc;
      dest_r      <= ms_dest;
      reg_write_r <= ms_reg_write;
      result_r    <= ms_result;
      load_op_r   <= ms_load_op;
    end
  end

  // Retired-instruction counter; every commit counts, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (ready_go_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Commit and forwarding outputs are combinational so a ready instruction writes in its own cycle.
  always_comb begin
    writes_rf_s = reg_write_r && (dest_r != 5'd0);
    if (held_load_s) begin
      wdata_s = aligned_s;
    end else begin
      wdata_s = result_r;
    end
    rf_wen      = ready_go_s && writes_rf_s;
    rf_waddr    = dest_r;
    rf_wdata    = wdata_s;
    fwd_valid   = ws_valid_s && writes_rf_s;
    fwd_pending = ws_valid_s && writes_rf_s && held_load_s && !data_rvalid;
    fwd_dest    = dest_r;
    fwd_data    = wdata_s;
    debug_wb_pc = pc_r;
    retire_cnt  = cnt_r;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run against a
// transaction-level model of the writeback stage.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        ms_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [4:0]  ms_dest;
  logic        ms_reg_write;
  logic [31:0] ms_result;
  logic        ms_is_load;
  logic [2:0]  ms_load_op;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic        fwd_pending;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic [31:0] debug_wb_pc;
  logic [31:0] retire_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt;

  wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ms_valid     (ms_valid),
    .ws_allowin   (ws_allowin),
    .ms_pc        (ms_pc),
    .ms_dest      (ms_dest),
    .ms_reg_write (ms_reg_write),
    .ms_result    (ms_result),
    .ms_is_load   (ms_is_load),
    .ms_load_op   (ms_load_op),
    .data_rvalid  (data_rvalid),
    .data_rdata   (data_rdata),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .fwd_valid    (fwd_valid),
    .fwd_pending  (fwd_pending),
    .fwd_dest     (fwd_dest),
    .fwd_data     (fwd_data),
    .debug_wb_pc  (debug_wb_pc),
    .retire_cnt   (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference load extraction using plain arithmetic on the addressed byte/half.
  function automatic logic [31:0] ref_load(logic [31:0] rdata, logic [1:0] off, logic [2:0] op);
    longint b;
    longint h;
    b = longint'((rdata >> (8 * off)) & 32'h0000_00FF);
    h = longint'((rdata >> (16 * off[1])) & 32'h0000_FFFF);
    case (op)
      3'd1:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd2:    return 32'(b);
      3'd3:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd4:    return 32'(h);
      default: return rdata;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ms_valid     = 1'b0;
    ms_pc        = 32'h0;
    ms_dest      = 5'd0;
    ms_reg_write = 1'b0;
    ms_result    = 32'h0;
    ms_is_load   = 1'b0;
    ms_load_op   = 3'd0;
    data_rvalid  = 1'b0;
    data_rdata   = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ws_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b want 1", ws_allowin); end
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", rf_wen); end
    checks++; if (fwd_valid !== 1'b0 || fwd_pending !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %b%b want 00", fwd_valid, fwd_pending); end
    checks++; if (retire_cnt !== 32'h0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_regs: cnt=%h waddr=%0d wdata=%h want 0", retire_cnt, rf_waddr, rf_wdata); end
    rst = 1'b0;
    ms_valid = 1'b1; ms_dest = 5'd7; ms_reg_write = 1'b1; ms_result = 32'h0000_00AA; ms_pc = 32'h0000_0100;
    next_cycle();
    ms_valid = 1'b0;
    next_cycle();
    ms_valid = 1'b1; ms_is_load = 1'b1; ms_load_op = 3'd0; ms_dest = 5'd9; ms_result = 32'h0000_2000;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (fwd_pending !== 1'b1 || retire_cnt !== 32'd1) begin errors++; $display("FAIL reset_pre_wait: pending=%b cnt=%0d want 1,1", fwd_pending, retire_cnt); end
    #1;
    rst = 1'b1;
    data_rvalid = 1'b1;
    data_rdata = 32'hCAFE_F00D;
    #1;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_mid_wen: got %b want 0", rf_wen); end
    checks++; if (ws_allowin !== 1'b1) begin errors++; $display("FAIL reset_mid_allowin: got %b want 1", ws_allowin); end
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_mid_cnt: got %0d want 0", retire_cnt); end
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_fwd: got %b want 0", fwd_valid); end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++; if (rf_wen !== 1'b0 || ws_allowin !== 1'b1 || retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_after: wen=%b allowin=%b cnt=%0d want 0,1,0", rf_wen, ws_allowin, retire_cnt); end
    exp_cnt = 32'd0;
    next_cycle();
  endtask

  task automatic test_add();
    ms_valid = 1'b1; ms_dest = 5'd5; ms_reg_write = 1'b1; ms_result = 32'h1234_5678;
    ms_is_load = 1'b0; ms_pc = 32'h0040_0010;
    @(negedge clk);
    checks++; if (ws_allowin !== 1'b1) begin errors++; $display("FAIL add_allowin: got %b want 1", ws_allowin); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5) begin errors++; $display("FAIL add_write: wen=%b waddr=%0d want 1,5", rf_wen, rf_waddr); end
    checks++; if (rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL add_wdata: got %h want 12345678", rf_wdata); end
    checks++; if (debug_wb_pc !== 32'h0040_0010) begin errors++; $display("FAIL add_pc: got %h want 00400010", debug_wb_pc); end
    checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL add_cnt_before: got %0d want %0d", retire_cnt, exp_cnt); end
    next_cycle();
    exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
    checks++; if (retire_cnt !== exp_cnt || rf_wen !== 1'b0) begin errors++; $display("FAIL add_cnt_after: cnt=%0d wen=%b want %0d,0", retire_cnt, rf_wen, exp_cnt); end
    next_cycle();
  endtask

  task automatic test_lb();
    logic [2:0]  ops[2]  = '{3'd1, 3'd2};
    logic [31:0] exps[2] = '{32'hFFFF_FF80, 32'h0000_0080};
    for (int k = 0; k < 2; k++) begin
      ms_valid = 1'b1; ms_is_load = 1'b1; ms_load_op = ops[k]; ms_dest = 5'd10;
      ms_reg_write = 1'b1; ms_result = 32'h0000_1003; ms_pc = 32'h0040_0020;
      next_cycle();
      idle_inputs();
      data_rdata = 32'h80FF_0011;
      for (int w = 0; w < 3; w++) begin
        @(negedge clk);
        checks++; if (fwd_pending !== 1'b1 || ws_allowin !== 1'b0 || rf_wen !== 1'b0) begin errors++; $display("FAIL lb_wait[%0d]: pending=%b allowin=%b wen=%b want 1,0,0", k, fwd_pending, ws_allowin, rf_wen); end
        next_cycle();
      end
      data_rvalid = 1'b1;
      @(negedge clk);
      checks++; if (rf_wen !== 1'b1 || rf_wdata !== exps[k]) begin errors++; $display("FAIL lb_data[%0d]: wen=%b wdata=%h want 1,%h", k, rf_wen, rf_wdata, exps[k]); end
      checks++; if (fwd_pending !== 1'b0 || fwd_data !== exps[k] || ws_allowin !== 1'b1) begin errors++; $display("FAIL lb_fwd[%0d]: pending=%b data=%h allowin=%b", k, fwd_pending, fwd_data, ws_allowin); end
      next_cycle();
      idle_inputs();
      exp_cnt = exp_cnt + 32'd1;
      @(negedge clk);
      checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL lb_cnt[%0d]: got %0d want %0d", k, retire_cnt, exp_cnt); end
      next_cycle();
    end
  endtask

  task automatic test_lh();
    logic [2:0]  ops[4]  = '{3'd3, 3'd4, 3'd3, 3'd3};
    logic [1:0]  offs[4] = '{2'd2, 2'd2, 2'd0, 2'd3};
    logic [31:0] exps[4] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_7FFF, 32'hFFFF_8001};
    for (int k = 0; k < 4; k++) begin
      ms_valid = 1'b1; ms_is_load = 1'b1; ms_load_op = ops[k]; ms_dest = 5'd12;
      ms_reg_write = 1'b1; ms_result = {30'h0000_0400, offs[k]};
      next_cycle();
      idle_inputs();
      data_rdata = 32'h8001_7FFF;
      data_rvalid = 1'b1;
      @(negedge clk);
      checks++; if (rf_wen !== 1'b1 || rf_wdata !== exps[k]) begin errors++; $display("FAIL lh[%0d]: wen=%b wdata=%h want 1,%h", k, rf_wen, rf_wdata, exps[k]); end
      next_cycle();
      exp_cnt = exp_cnt + 32'd1;
      idle_inputs();
    end
    @(negedge clk);
    checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL lh_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] start;
    start = retire_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        ms_valid = 1'b1; ms_is_load = 1'b0; ms_reg_write = 1'b1;
        ms_dest = 5'(i + 1); ms_result = 32'h0000_0100 + 32'(i);
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      checks++; if (ws_allowin !== 1'b1) begin errors++; $display("FAIL stream_allowin[%0d]: got %b want 1", i, ws_allowin); end
      if (i > 0) begin
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== 32'h0000_0100 + 32'(i - 1)) begin errors++; $display("FAIL stream_commit[%0d]: wen=%b waddr=%0d wdata=%h", i, rf_wen, rf_waddr, rf_wdata); end
      end
      next_cycle();
    end
    exp_cnt = exp_cnt + 32'd4;
    @(negedge clk);
    checks++; if (retire_cnt !== start + 32'd4) begin errors++; $display("FAIL stream_cnt: got %0d want %0d", retire_cnt, start + 32'd4); end
    next_cycle();
  endtask

  task automatic test_dest0();
    idle_inputs();
    data_rvalid = 1'b1;
    @(negedge clk);
    checks++; if (rf_wen !== 1'b0 || ws_allowin !== 1'b1 || fwd_valid !== 1'b0) begin errors++; $display("FAIL stray_rvalid: wen=%b allowin=%b fwd=%b want 0,1,0", rf_wen, ws_allowin, fwd_valid); end
    next_cycle();
    ms_valid = 1'b1; ms_dest = 5'd0; ms_reg_write = 1'b1; ms_result = 32'h0000_DEAD; ms_pc = 32'h0040_0080;
    data_rvalid = 1'b0;
    next_cycle();
    idle_inputs();
    data_rvalid = 1'b1;
    @(negedge clk);
    checks++; if (rf_wen !== 1'b0 || fwd_valid !== 1'b0 || ws_allowin !== 1'b1) begin errors++; $display("FAIL dest0_commit: wen=%b fwd=%b allowin=%b want 0,0,1", rf_wen, fwd_valid, ws_allowin); end
    checks++; if (debug_wb_pc !== 32'h0040_0080) begin errors++; $display("FAIL dest0_pc: got %h want 00400080", debug_wb_pc); end
    next_cycle();
    exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
    checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL dest0_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
    next_cycle();
    @(negedge clk);
    checks++; if (retire_cnt !== exp_cnt || rf_wen !== 1'b0) begin errors++; $display("FAIL stray_no_change: cnt=%0d wen=%b want %0d,0", retire_cnt, rf_wen, exp_cnt); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_random();
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [4:0]  m_dest = 5'd0;
    logic        m_rw = 1'b0;
    logic [31:0] m_res = 32'h0;
    logic        m_ld = 1'b0;
    logic [2:0]  m_op = 3'd0;
    logic        e_ready, e_allow, e_wen, e_fv, e_fp;
    logic [31:0] e_data;
    for (int c = 0; c < 400; c++) begin
      ms_valid     = ($urandom_range(0, 9) < 6);
      ms_pc        = $urandom;
      ms_dest      = 5'($urandom_range(0, 31));
      ms_reg_write = ($urandom_range(0, 3) != 0);
      ms_result    = $urandom;
      ms_is_load   = $urandom_range(0, 1) == 1;
      ms_load_op   = 3'($urandom_range(0, 7));
      data_rvalid  = $urandom_range(0, 1) == 1;
      data_rdata   = $urandom;
      e_ready = m_valid && (!m_ld || data_rvalid);
      e_allow = !m_valid || e_ready;
      e_fv    = m_valid && m_rw && (m_dest != 5'd0);
      e_fp    = e_fv && m_ld && !data_rvalid;
      e_wen   = e_ready && m_rw && (m_dest != 5'd0);
      e_data  = m_ld ? ref_load(data_rdata, m_res[1:0], m_op) : m_res;
      @(negedge clk);
      checks++; if (ws_allowin !== e_allow || rf_wen !== e_wen) begin errors++; $display("FAIL rand_hs[%0d]: allowin=%b wen=%b want %b,%b", c, ws_allowin, rf_wen, e_allow, e_wen); end
      checks++; if (fwd_valid !== e_fv || fwd_pending !== e_fp) begin errors++; $display("FAIL rand_fwd[%0d]: valid=%b pending=%b want %b,%b", c, fwd_valid, fwd_pending, e_fv, e_fp); end
      checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", c, retire_cnt, exp_cnt); end
      if (e_ready) begin
        checks++; if (rf_wdata !== e_data || debug_wb_pc !== m_pc) begin errors++; $display("FAIL rand_data[%0d]: wdata=%h pc=%h want %h,%h", c, rf_wdata, debug_wb_pc, e_data, m_pc); end
      end
      if (e_fv) begin
        checks++; if (rf_waddr !== m_dest || fwd_dest !== m_dest) begin errors++; $display("FAIL rand_dest[%0d]: waddr=%0d fdest=%0d want %0d", c, rf_waddr, fwd_dest, m_dest); end
      end
      @(posedge clk);
      if (e_ready) exp_cnt = exp_cnt + 32'd1;
      if (ms_valid && e_allow) begin
        m_valid = 1'b1; m_pc = ms_pc; m_dest = ms_dest; m_rw = ms_reg_write;
        m_res = ms_result; m_ld = ms_is_load; m_op = ms_load_op;
      end else if (e_ready) begin
        m_valid = 1'b0;
      end
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    exp_cnt = 32'd0;
    test_reset();
    test_add();
    test_lb();
    test_lh();
    test_back_to_back();
    test_dest0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
